dispatch_ctrl: RTL and testbench
================================

Name: dispatch_ctrl

Overview:
- Sits between the decode stage and the execution back end.
- Buffers one decoded instruction and allocates a reorder-buffer (ROB) tag for it.
- Routes the instruction to the ALU issue queue or the memory issue queue based on its functional-unit flags.
- Tracks ROB occupancy, stalls decode on back-pressure or a full ROB, and clears all state on a pipeline flush.

Parameters:
- ROB_DEPTH, 16: number of ROB entries; must be a power of two.
- TAG_W, 4: ROB tag width; equals log2(ROB_DEPTH).
- STALL_W, 16: width of the stall performance counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- valid_in  in  1  decode output holds a valid instruction.
- ready_in  out  1  dispatch_ctrl accepts data_in this cycle.
- data_in  in  decode_data  decoded instruction (pc, rs1, rs2, rd, imm, ALUOp, Opcode, fu_mem, fu_alu).
- alu_valid  out  1  disp_data/disp_tag are offered to the ALU issue queue.
- alu_ready  in  1  ALU issue queue can accept.
- mem_valid  out  1  disp_data/disp_tag are offered to the memory issue queue.
- mem_ready  in  1  memory issue queue can accept.
- disp_data  out  decode_data  the held instruction.
- disp_tag  out  TAG_W  ROB tag allocated to disp_data.
- rob_commit  in  1  ROB retired one entry this cycle.
- flush  in  1  synchronous pipeline flush (mispredict or exception).
- rob_count  out  TAG_W+1  current ROB occupancy.
- stall_cycles  out  STALL_W  saturating count of stall cycles.

Behaviour:
- Reset (async, immediate):
  - holding register empty;
  - disp_data = 0, disp_tag = 0;
  - tail pointer = 0, rob_count = 0, stall_cycles = 0;
  - alu_valid = 0, mem_valid = 0, ready_in = 0 while reset is high.
- State machine, two states:
  - EMPTY: no instruction held.
  - HELD: holding register valid.
- Routing, computed from the held instruction:
  - route_mem = fu_mem.
  - fu_mem has priority when both fu_mem and fu_alu are 1.
  - Both flags 0: routes to the ALU.
- Offer gating:
  - rob_full = (rob_count == ROB_DEPTH).
  - can_go = HELD && !rob_full && !flush.
  - mem_valid = can_go && route_mem.
  - alu_valid = can_go && !route_mem.
  - valid never depends on the ready of the same path.
  - At most one of alu_valid/mem_valid is high in any cycle.
- Dispatch fire: fire = (alu_valid && alu_ready) || (mem_valid && mem_ready).
- ready_in = !reset && !flush && (EMPTY || fire). This is a single-buffer pass-through, so back-to-back dispatch is allowed: 1 instruction per cycle.
- Accept (valid_in && ready_in):
  - next cycle: HELD, with disp_data = data_in.
  - latency from accept to offer is 1 cycle.
- Fire without a new accept: next state is EMPTY.
- Fire and accept in the same cycle: stays HELD with the new data.
- disp_tag = tail pointer while HELD.
- On fire:
  - tail increments modulo ROB_DEPTH (wraps from ROB_DEPTH-1 to 0).
  - rob_count increments.
- rob_commit: rob_count decrements. rob_commit when rob_count == 0 is ignored (no underflow).
- Fire and rob_commit in the same cycle: rob_count unchanged.
- ROB full: dispatch is blocked even if rob_commit is asserted in the same cycle (no bypass); the instruction dispatches the following cycle.
- Flush, effective at the next edge:
  - next state EMPTY; tail = 0; rob_count = 0;
  - disp_data is not cleared, but both valids are low;
  - the flush cycle has no fire and no accept;
  - rob_commit in the flush cycle is ignored;
  - flush overrides all other events.
- Stall counter: stall_cycles increments by 1 in each cycle where HELD && !fire && !flush. It saturates at all-ones and clears only on reset.
- Data stability: disp_data and disp_tag hold steady while a valid is high and unacknowledged.

Test Plan:
- ALU stream: reset; present 3 instructions with fu_alu=1 back-to-back, alu_ready=1 → alu_valid on cycles 1-3, disp_tag 0,1,2, ready_in stays 1, rob_count=3, stall_cycles=0.
- Memory back-pressure: instruction with fu_mem=1, fu_alu=1 and mem_ready=0 for 4 cycles → mem_valid=1, alu_valid=0, disp_data stable, ready_in=0, stall_cycles=4; assert mem_ready → fire, disp_tag=0.
- ROB full with simultaneous commit: dispatch 16 instructions → rob_count=16, tag wraps 15→0; 17th held with valids 0; rob_commit pulse → 17th dispatches the following cycle with disp_tag=0, rob_count back to 16.
- Simultaneous commit and fire: rob_count=5, fire and rob_commit in the same cycle → rob_count stays 5; rob_commit at rob_count=0 → stays 0.
- Flush mid-stall: HELD with tag 7, rob_count=7, flush=1 together with valid_in=1 → ready_in=0, next cycle EMPTY, rob_count=0; next dispatch gets disp_tag=0.
- Async reset: assert reset between clock edges while HELD → valids drop immediately; rob_count=0 and stall_cycles=0 without a clock edge.

Source files
------------

// File: rtl/dispatch_ctrl.sv
// Single-entry dispatch buffer: allocates ROB tags, routes to ALU or memory issue queue.
// data_in layout: {pc[31:0], rs1/rs2/rd/imm/ALUOp/Opcode [57:0], fu_mem, fu_alu}.
module dispatch_ctrl #(
   parameter int ROB_DEPTH = 16,
   parameter int TAG_W     = 4,
   parameter int STALL_W   = 16,
   parameter int DATA_W    = 92
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               valid_in,
   output logic               ready_in,
   input  logic [DATA_W-1:0]  data_in,
   output logic               alu_valid,
   input  logic               alu_ready,
   output logic               mem_valid,
   input  logic               mem_ready,
   output logic [DATA_W-1:0]  disp_data,
   output logic [TAG_W-1:0]   disp_tag,
   input  logic               rob_commit,
   input  logic               flush,
   output logic [TAG_W:0]     rob_count,
   output logic [STALL_W-1:0] stall_cycles
);

   typedef enum logic {EMPTY, HELD} state_t;

   localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(ROB_DEPTH);

   state_t               state_q, state_d;
   logic [DATA_W-1:0]    data_q, data_d;
   logic [TAG_W-1:0]     tail_q, tail_d;
   logic [TAG_W:0]       count_q, count_d;
   logic [STALL_W-1:0]   stall_q, stall_d;

   logic route_mem, rob_full, can_go, fire, accept, commit_ok;

   assign route_mem = data_q[1];
   assign rob_full  = (count_q == FULL_CNT);
   assign can_go    = (state_q == HELD) && !rob_full && !flush;
   assign mem_valid = can_go && route_mem;
   assign alu_valid = can_go && !route_mem;
   assign fire      = (alu_valid && alu_ready) || (mem_valid && mem_ready);
   assign ready_in  = !reset && !flush && ((state_q == EMPTY) || fire);
   assign accept    = valid_in && ready_in;
   assign commit_ok = rob_commit && (count_q != '0);

   assign disp_data    = data_q;
   assign disp_tag     = tail_q;
   assign rob_count    = count_q;
   assign stall_cycles = stall_q;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      tail_d  = tail_q;
      count_d = count_q;
      stall_d = stall_q;
      if ((state_q == HELD) && !fire && !flush && (stall_q != '1))
         stall_d = stall_q + STALL_W'(1);
      if (flush) begin
         // Flush wins over commit, fire and accept; held data is left in place.
         state_d = EMPTY;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (accept) begin
            state_d = HELD;
            data_d  = data_in;
         end else if (fire) begin
            state_d = EMPTY;
         end
         if (fire)
            tail_d = tail_q + TAG_W'(1);
         case ({fire, commit_ok})
            2'b10:   count_d = count_q + (TAG_W+1)'(1);
            2'b01:   count_d = count_q - (TAG_W+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= EMPTY;
         data_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         stall_q <= stall_d;
      end
   end

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Bench for dispatch_ctrl: directed vector table, hand sequences, and random run vs a queue-based ROB model.
module tb_dispatch_ctrl;
   localparam int DEPTH = 16;
   localparam int TW    = 4;
   localparam int SW    = 16;
   localparam int DW    = 92;

   logic          clk = 1'b0;
   logic          reset;
   logic          valid_in, ready_in;
   logic [DW-1:0] data_in;
   logic          alu_valid, alu_ready, mem_valid, mem_ready;
   logic [DW-1:0] disp_data;
   logic [TW-1:0] disp_tag;
   logic          rob_commit, flush;
   logic [TW:0]   rob_count;
   logic [SW-1:0] stall_cycles;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   dispatch_ctrl #(.ROB_DEPTH(DEPTH), .TAG_W(TW), .STALL_W(SW), .DATA_W(DW)) dut (
      .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in), .data_in(data_in),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .mem_valid(mem_valid), .mem_ready(mem_ready),
      .disp_data(disp_data), .disp_tag(disp_tag), .rob_commit(rob_commit), .flush(flush),
      .rob_count(rob_count), .stall_cycles(stall_cycles)
   );

   typedef struct {
      bit v, fm, fa, ar, mr, cm, fl;
      int pc;
      bit rdy, av, mv;
      int tag, cnt, stall, epc;   // tag/epc of -1: not checked
   } vec_t;

   vec_t tq[$];

   function automatic logic [DW-1:0] mk(int pc, bit fm, bit fa);
      mk = {32'(pc), 58'(pc * 7 + 1), fm, fa};
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input bit v, input logic [DW-1:0] d, input bit ar, input bit mr,
                        input bit cm, input bit fl);
      valid_in = v; data_in = d; alu_ready = ar; mem_ready = mr; rob_commit = cm; flush = fl;
   endtask

   task automatic add(input bit v, fm, fa, ar, mr, cm, fl, input int pc,
                      input bit rdy, av, mv, input int tag, cnt, stall, epc);
      vec_t r;
      r.v = v; r.fm = fm; r.fa = fa; r.ar = ar; r.mr = mr; r.cm = cm; r.fl = fl; r.pc = pc;
      r.rdy = rdy; r.av = av; r.mv = mv; r.tag = tag; r.cnt = cnt; r.stall = stall; r.epc = epc;
      tq.push_back(r);
   endtask

   // Reference model: the ROB is a queue of allocated tags; tail is dispatches since flush mod depth.
   bit            m_held;
   logic [DW-1:0] m_data;
   int            m_ndisp, m_stall;
   int            m_rob[$];

   task automatic model_reset();
      m_held = 0; m_data = '0; m_ndisp = 0; m_stall = 0; m_rob.delete();
   endtask

   task automatic model_cycle();
      bit full, go, ismem, fire, rdy, exp_av, exp_mv;
      full   = (m_rob.size() == DEPTH);
      go     = m_held && !full && !flush;
      ismem  = m_data[1];
      exp_mv = go && ismem;
      exp_av = go && !ismem;
      fire   = ismem ? (exp_mv && mem_ready) : (exp_av && alu_ready);
      rdy    = !flush && (!m_held || fire);
      chk("rnd_ready", DW'(ready_in), DW'(rdy));
      chk("rnd_alu_valid", DW'(alu_valid), DW'(exp_av));
      chk("rnd_mem_valid", DW'(mem_valid), DW'(exp_mv));
      chk("rnd_rob_count", DW'(rob_count), DW'(m_rob.size()));
      chk("rnd_stall", DW'(stall_cycles), DW'(m_stall));
      if (go) begin
         chk("rnd_tag", DW'(disp_tag), DW'(m_ndisp % DEPTH));
         chk("rnd_data", disp_data, m_data);
      end
      if (flush) begin
         m_held = 0; m_ndisp = 0; m_rob.delete();
      end else begin
         if (m_held && !fire && m_stall < (1 << SW) - 1) m_stall++;
         if (rob_commit && m_rob.size() > 0) void'(m_rob.pop_front());
         if (fire) begin
            m_rob.push_back(m_ndisp % DEPTH);
            m_ndisp++;
         end
         if (valid_in && rdy) begin
            m_held = 1; m_data = data_in;
         end else if (fire) begin
            m_held = 0;
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      drive(0, '0, 0, 0, 0, 0);
      #1;
      chk("rst_ready", DW'(ready_in), '0);
      chk("rst_valids", DW'({alu_valid, mem_valid}), '0);
      chk("rst_count", DW'(rob_count), '0);
      chk("rst_stall", DW'(stall_cycles), '0);
      chk("rst_tag", DW'(disp_tag), '0);
      chk("rst_data", disp_data, '0);
      @(negedge clk);
      reset = 1'b0;

      //  v fm fa ar mr cm fl pc    rdy av mv tag cnt stall epc
      add(1, 0, 1, 1, 0, 0, 0, 100,  1, 0, 0, -1, 0, 0, -1);
      add(1, 0, 1, 1, 0, 0, 0, 101,  1, 1, 0,  0, 0, 0, 100);
      add(1, 0, 1, 1, 0, 0, 0, 102,  1, 1, 0,  1, 1, 0, 101);
      add(0, 0, 0, 1, 0, 0, 0, 0,    1, 1, 0,  2, 2, 0, 102);
      add(1, 1, 1, 0, 0, 0, 0, 200,  1, 0, 0, -1, 3, 0, -1);
      add(1, 0, 0, 0, 0, 0, 0, 201,  0, 0, 1,  3, 3, 0, 200);
      add(1, 0, 0, 0, 0, 0, 0, 201,  0, 0, 1,  3, 3, 1, 200);
      add(1, 0, 0, 0, 0, 0, 0, 201,  0, 0, 1,  3, 3, 2, 200);
      add(1, 0, 0, 0, 0, 0, 0, 201,  0, 0, 1,  3, 3, 3, 200);
      add(1, 0, 0, 0, 1, 0, 0, 201,  1, 0, 1,  3, 3, 4, 200);
      add(0, 0, 0, 0, 1, 1, 0, 0,    0, 1, 0,  4, 4, 4, 201);
      add(0, 0, 0, 1, 0, 1, 0, 0,    1, 1, 0,  4, 3, 5, 201);
      add(0, 0, 0, 0, 0, 1, 0, 0,    1, 0, 0, -1, 3, 5, -1);
      add(1, 0, 1, 0, 0, 0, 1, 250,  0, 0, 0, -1, 2, 5, -1);
      add(1, 0, 1, 0, 0, 1, 0, 300,  1, 0, 0, -1, 0, 5, -1);
      add(0, 0, 0, 0, 0, 0, 1, 0,    0, 0, 0, -1, 0, 5, 300);
      add(0, 0, 0, 0, 0, 0, 0, 0,    1, 0, 0, -1, 0, 5, -1);

      foreach (tq[i]) begin
         drive(tq[i].v, mk(tq[i].pc, tq[i].fm, tq[i].fa), tq[i].ar, tq[i].mr, tq[i].cm, tq[i].fl);
         #1;
         chk($sformatf("vec%0d_ready", i), DW'(ready_in), DW'(tq[i].rdy));
         chk($sformatf("vec%0d_alu_valid", i), DW'(alu_valid), DW'(tq[i].av));
         chk($sformatf("vec%0d_mem_valid", i), DW'(mem_valid), DW'(tq[i].mv));
         chk($sformatf("vec%0d_count", i), DW'(rob_count), DW'(tq[i].cnt));
         chk($sformatf("vec%0d_stall", i), DW'(stall_cycles), DW'(tq[i].stall));
         if (tq[i].tag >= 0) chk($sformatf("vec%0d_tag", i), DW'(disp_tag), DW'(tq[i].tag));
         if (tq[i].epc >= 0) chk($sformatf("vec%0d_pc", i), DW'(disp_data[DW-1 -: 32]), DW'(tq[i].epc));
         @(negedge clk);
      end

      // ROB fill: 17 back-to-back ALU instructions, tag wrap, full blocking, commit with no bypass.
      #2 reset = 1'b1;
      #1 reset = 1'b0;
      for (int k = 0; k <= 16; k++) begin
         drive(1, mk(400 + k, 0, 1), 1, 0, 0, 0);
         #1;
         if (k > 0) begin
            chk($sformatf("fill%0d_alu_valid", k), DW'(alu_valid), DW'(1));
            chk($sformatf("fill%0d_tag", k), DW'(disp_tag), DW'((k - 1) % DEPTH));
            chk($sformatf("fill%0d_count", k), DW'(rob_count), DW'(k - 1));
         end
         @(negedge clk);
      end
      drive(0, '0, 1, 1, 1, 0);
      #1;
      chk("full_count", DW'(rob_count), DW'(DEPTH));
      chk("full_valids", DW'({alu_valid, mem_valid}), '0);
      chk("full_ready", DW'(ready_in), '0);
      @(negedge clk);
      drive(0, '0, 1, 1, 0, 0);
      #1;
      chk("after_commit_alu_valid", DW'(alu_valid), DW'(1));
      chk("after_commit_tag", DW'(disp_tag), '0);
      chk("after_commit_pc", DW'(disp_data[DW-1 -: 32]), DW'(416));
      chk("after_commit_count", DW'(rob_count), DW'(DEPTH - 1));
      @(negedge clk);
      #1;
      chk("refull_count", DW'(rob_count), DW'(DEPTH));
      chk("refull_stall", DW'(stall_cycles), DW'(1));

      // Async reset while an instruction is held and offered.
      @(negedge clk);
      drive(0, '0, 0, 0, 1, 0);
      @(negedge clk);
      drive(1, mk(500, 0, 1), 0, 0, 0, 0);
      @(negedge clk);
      #1;
      chk("pre_rst_alu_valid", DW'(alu_valid), DW'(1));
      chk("pre_rst_tag", DW'(disp_tag), DW'(1));
      chk("pre_rst_count", DW'(rob_count), DW'(DEPTH - 1));
      #1 reset = 1'b1;
      #1;
      chk("async_valids", DW'({alu_valid, mem_valid}), '0);
      chk("async_ready", DW'(ready_in), '0);
      chk("async_count", DW'(rob_count), '0);
      chk("async_stall", DW'(stall_cycles), '0);
      chk("async_data", disp_data, '0);

      // Random run against the model.
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      for (int c = 0; c < 4000; c++) begin
         drive(($urandom % 4) != 0, DW'({$urandom, $urandom, $urandom}),
               ($urandom % 10) < 7, ($urandom % 10) < 7, ($urandom % 10) < 4,
               ($urandom % 40) == 0);
         #1;
         model_cycle();
         @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
